xge_pkt_rx_reader: RTL and testbench
====================================

// Module: xge_pkt_rx_reader
// PURPOSE
//  Consumer for the MAC receive packet interface (pkt_rx_*) on the 156.25 MHz core clock.
//  Drives pkt_rx_ren when pkt_rx_avail, reads one frame per pass and checks SOP/EOP framing.
//  Computes the byte length from pkt_rx_mod and posts a per-frame result record over a valid/ready handshake.
//  Keeps good/bad frame counters; used in loopback benches and as the rx sink in system builds.
// PARAMETERS
//  MAX_LEN  16'd9600  frame byte limit; frames longer than this are flagged bad
//  TIMEOUT  16        max consecutive READ cycles without pkt_rx_val before the frame is aborted
// PORTS
//  clk_156m25      in   1   core clock, all logic on posedge
//  reset_156m25_n  in   1   asynchronous, active-low reset
//  enable          in   1   permits starting a new frame read
//  cnt_clr         in   1   synchronous clear of cnt_good/cnt_bad
//  pkt_rx_avail    in   1   MAC has a complete frame buffered
//  pkt_rx_val      in   1   data/flags valid this cycle (one cycle after the ren that fetched them)
//  pkt_rx_sop      in   1   first word of frame
//  pkt_rx_eop      in   1   last word of frame
//  pkt_rx_err      in   1   MAC error flag, meaningful with eop
//  pkt_rx_mod      in   3   valid bytes on eop word; 0 means 8
//  pkt_rx_data     in   64  frame data
//  pkt_rx_ren      out  1   read enable to MAC rx FIFO
//  frm_valid       out  1   result record valid
//  frm_ready       in   1   result record accepted when frm_valid&&frm_ready
//  frm_len         out  16  frame byte count (saturates at 16'hFFFF)
//  frm_err         out  1   frame bad (MAC err | framing | oversize | timeout)
//  frm_word0       out  64  first data word of frame (DA + 2 bytes of SA)
//  cnt_good        out  32  frames completed with frm_err=0, wraps
//  cnt_bad         out  32  frames completed with frm_err=1, wraps
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; internal len, err, idle-timer and started flag cleared.
//  FSM: IDLE -> READ -> RESULT -> IDLE.
//  IDLE: when enable && pkt_rx_avail, go to READ next cycle; pkt_rx_ren=0 while in IDLE.
//  READ: pkt_rx_ren=1, except it is combinationally forced 0 in the cycle where pkt_rx_val&&pkt_rx_eop.
//   - That cycle's ren would fetch the next frame, so the kill prevents any word beyond EOP being read.
//  Per val word:
//   - len += eop ? (mod==0 ? 8 : mod) : 8, saturating at 16'hFFFF.
//   - The first val word of the frame is captured into frm_word0 and sets started.
//   - First word without sop -> err=1. A sop on a later word -> err=1; counting continues.
//   - len > MAX_LEN at any point -> err=1.
//   - eop word: err |= pkt_rx_err. Next state is RESULT.
//  Timeout: idle-timer counts READ cycles with pkt_rx_val=0 and resets on every val.
//   - When it reaches TIMEOUT: ren drops the same cycle, err=1, go to RESULT with len as accumulated.
//  RESULT: frm_valid=1 with frm_len/frm_err/frm_word0 stable until frm_valid&&frm_ready.
//   - Returns to IDLE the following cycle; pkt_rx_ren=0 throughout.
//   - Earliest next ren is one cycle after IDLE is entered.
//  Counters: on entry to RESULT, cnt_good or cnt_bad increments by 1 (32-bit wrap).
//   - cnt_clr has priority over a same-cycle increment: the counter ends at 0.
//  enable dropped during READ: the current frame completes normally; no new frame starts.
//  pkt_rx_val while in IDLE/RESULT: ignored; the word is not counted.
//  Reset mid-frame: immediate return to reset state; the MAC is responsible for discarding its partial frame.
//  Latency: eop sampled at edge N -> frm_valid=1 after edge N (same edge that enters RESULT).
// TESTING
//  1. 64B frame: 8 val words, sop on w0, eop on w7, mod=0
//     -> frm_len=64, frm_err=0, cnt_good=1, pkt_rx_ren=0 in the eop cycle.
//  2. 61B frame: 8 words, eop with mod=5 -> frm_len=61, frm_err=0; frm_word0 equals w0 data.
//  3. 128B frame with pkt_rx_err=1 on eop -> frm_len=128, frm_err=1, cnt_bad=1, cnt_good unchanged.
//  4. Framing: w0 without sop; separately, sop repeated on w3 -> frm_err=1 in both cases.
//  5. Timeout: avail=1 but val never asserted -> after TIMEOUT=16 cycles, ren=0, frm_valid=1, frm_len=0, frm_err=1.
//  6. Back-pressure and clear:
//     - frm_ready=0 for 20 cycles with avail=1 -> ren stays 0 and the record is held stable; accepted on frm_ready=1.
//     - cnt_clr in the same cycle as an increment -> counter reads 0.

Source files
------------

// File: rtl/xge_pkt_rx_reader.sv
// MAC rx packet reader: pulls one frame per pass from the pkt_rx_* FIFO,
// checks SOP/EOP framing and length, posts a result record, counts frames.
module xge_pkt_rx_reader #(
    parameter logic [15:0] MAX_LEN = 16'd9600,
    parameter int          TIMEOUT = 16
) (
    input  logic        clk_156m25,
    input  logic        reset_156m25_n,
    input  logic        enable,
    input  logic        cnt_clr,
    input  logic        pkt_rx_avail,
    input  logic        pkt_rx_val,
    input  logic        pkt_rx_sop,
    input  logic        pkt_rx_eop,
    input  logic        pkt_rx_err,
    input  logic [2:0]  pkt_rx_mod,
    input  logic [63:0] pkt_rx_data,
    output logic        pkt_rx_ren,
    output logic        frm_valid,
    input  logic        frm_ready,
    output logic [15:0] frm_len,
    output logic        frm_err,
    output logic [63:0] frm_word0,
    output logic [31:0] cnt_good,
    output logic [31:0] cnt_bad
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        RESULT
    } state_t;

    state_t state, state_nxt;

    logic [15:0]   len_q;
    logic          err_q;
    logic          started_q;
    logic [TW-1:0] tmr_q;
    logic [63:0]   word0_q;

    logic          word_v;
    logic          tmo_hit;
    logic          start;
    logic          enter_result;
    logic [3:0]    add;
    logic [16:0]   sum;
    logic [15:0]   len_nxt;
    logic          err_nxt;

    // Per-word length/error update, evaluated only for val words in READ
    always_comb begin
        word_v  = (state == READ) && pkt_rx_val;
        add     = (pkt_rx_eop && (pkt_rx_mod != 3'd0)) ? {1'b0, pkt_rx_mod} : 4'd8;
        sum     = {1'b0, len_q} + {13'd0, add};
        len_nxt = sum[16] ? 16'hFFFF : sum[15:0];
        tmo_hit = (state == READ) && !pkt_rx_val
                  && (tmr_q == TW'(TIMEOUT - 1));
        err_nxt = err_q;
        if (word_v) begin
            if (!started_q && !pkt_rx_sop) err_nxt = 1'b1;
            if (started_q && pkt_rx_sop)   err_nxt = 1'b1;
            if (len_nxt > MAX_LEN)         err_nxt = 1'b1;
            if (pkt_rx_eop && pkt_rx_err)  err_nxt = 1'b1;
        end
        if (tmo_hit) err_nxt = 1'b1;
    end

    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) state <= IDLE;
        else                 state <= state_nxt;
    end

    // ren is killed on the eop word so the next frame is never fetched
    always_comb begin
        state_nxt  = state;
        pkt_rx_ren = 1'b0;
        frm_valid  = 1'b0;
        start      = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable && pkt_rx_avail) begin
                    state_nxt = READ;
                    start     = 1'b1;
                end
            end
            READ: begin
                pkt_rx_ren = 1'b1;
                if (word_v && pkt_rx_eop) begin
                    pkt_rx_ren = 1'b0;
                    state_nxt  = RESULT;
                end else if (tmo_hit) begin
                    pkt_rx_ren = 1'b0;
                    state_nxt  = RESULT;
                end
            end
            RESULT: begin
                frm_valid = 1'b1;
                if (frm_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign enter_result = (state == READ) && (state_nxt == RESULT);

    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            len_q     <= '0;
            err_q     <= 1'b0;
            started_q <= 1'b0;
            tmr_q     <= '0;
            word0_q   <= '0;
        end else if (start) begin
            len_q     <= '0;
            err_q     <= 1'b0;
            started_q <= 1'b0;
            tmr_q     <= '0;
        end else if (state == READ) begin
            err_q <= err_nxt;
            if (pkt_rx_val) begin
                len_q <= len_nxt;
                tmr_q <= '0;
                if (!started_q) begin
                    word0_q   <= pkt_rx_data;
                    started_q <= 1'b1;
                end
            end else begin
                tmr_q <= tmr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            cnt_good <= '0;
            cnt_bad  <= '0;
        end else if (cnt_clr) begin
            cnt_good <= '0;
            cnt_bad  <= '0;
        end else if (enter_result) begin
            if (err_nxt) cnt_bad  <= cnt_bad + 32'd1;
            else         cnt_good <= cnt_good + 32'd1;
        end
    end

    assign frm_len   = len_q;
    assign frm_err   = err_q;
    assign frm_word0 = word0_q;

endmodule

// File: tb/tb_xge_pkt_rx_reader.sv
// Directed bench for xge_pkt_rx_reader with a ren-driven MAC FIFO model.
`timescale 1ns/100ps
module tb_xge_pkt_rx_reader;

    logic        clk_156m25 = 1'b0;
    logic        reset_156m25_n = 1'b0;
    logic        enable = 1'b0;
    logic        cnt_clr = 1'b0;
    logic        pkt_rx_avail = 1'b0;
    logic        pkt_rx_val = 1'b0;
    logic        pkt_rx_sop = 1'b0;
    logic        pkt_rx_eop = 1'b0;
    logic        pkt_rx_err = 1'b0;
    logic [2:0]  pkt_rx_mod = 3'd0;
    logic [63:0] pkt_rx_data = 64'd0;
    logic        pkt_rx_ren;
    logic        frm_valid;
    logic        frm_ready = 1'b0;
    logic [15:0] frm_len;
    logic        frm_err;
    logic [63:0] frm_word0;
    logic [31:0] cnt_good;
    logic [31:0] cnt_bad;

    int checks = 0;
    int errors = 0;

    logic [63:0] fd   [0:2047];
    logic        fsop [0:2047];
    logic        feop [0:2047];
    logic        ferr [0:2047];
    logic [2:0]  fmod [0:2047];
    int   nwords = 0;
    int   idx = 0;
    int   ren_cnt = 0;
    logic ren_s = 1'b0;
    logic ren_at_eop = 1'b1;
    logic clr_on_eop = 1'b0;

    xge_pkt_rx_reader dut (
        .clk_156m25     (clk_156m25),
        .reset_156m25_n (reset_156m25_n),
        .enable         (enable),
        .cnt_clr        (cnt_clr),
        .pkt_rx_avail   (pkt_rx_avail),
        .pkt_rx_val     (pkt_rx_val),
        .pkt_rx_sop     (pkt_rx_sop),
        .pkt_rx_eop     (pkt_rx_eop),
        .pkt_rx_err     (pkt_rx_err),
        .pkt_rx_mod     (pkt_rx_mod),
        .pkt_rx_data    (pkt_rx_data),
        .pkt_rx_ren     (pkt_rx_ren),
        .frm_valid      (frm_valid),
        .frm_ready      (frm_ready),
        .frm_len        (frm_len),
        .frm_err        (frm_err),
        .frm_word0      (frm_word0),
        .cnt_good       (cnt_good),
        .cnt_bad        (cnt_bad)
    );

    always #3.2 clk_156m25 = ~clk_156m25;

    always @(negedge clk_156m25) begin
        ren_s = pkt_rx_ren;
        if (pkt_rx_ren) ren_cnt++;
        if (pkt_rx_val && pkt_rx_eop) ren_at_eop = pkt_rx_ren;
    end

    // MAC FIFO: a word fetched by ren appears the following cycle
    always @(posedge clk_156m25) begin
        #1;
        if (ren_s && idx < nwords) begin
            pkt_rx_val  = 1'b1;
            pkt_rx_data = fd[idx];
            pkt_rx_sop  = fsop[idx];
            pkt_rx_eop  = feop[idx];
            pkt_rx_err  = ferr[idx];
            pkt_rx_mod  = fmod[idx];
            cnt_clr     = clr_on_eop && feop[idx];
            idx++;
        end else begin
            pkt_rx_val  = 1'b0;
            pkt_rx_sop  = 1'b0;
            pkt_rx_eop  = 1'b0;
            pkt_rx_err  = 1'b0;
            pkt_rx_mod  = 3'd0;
            cnt_clr     = 1'b0;
        end
    end

    task automatic load_frame(input int n, input logic [31:0] tag,
                              input logic [2:0] mod, input logic err);
        for (int i = 0; i < n; i++) begin
            fd[i]   = {tag, 32'(i)};
            fsop[i] = (i == 0);
            feop[i] = (i == n - 1);
            fmod[i] = (i == n - 1) ? mod : 3'd0;
            ferr[i] = (i == n - 1) ? err : 1'b0;
        end
        nwords = n;
    endtask

    task automatic run_frame(input int lim, input bit keep_avail);
        bit ok;
        ok = 0;
        @(negedge clk_156m25);
        idx = 0;
        ren_cnt = 0;
        ren_at_eop = 1'b1;
        pkt_rx_avail = 1'b1;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk_156m25);
            if (frm_valid) begin
                ok = 1;
                break;
            end
        end
        if (!keep_avail) pkt_rx_avail = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL frm_valid_wait: no result within %0d cycles", lim);
        end
    endtask

    task automatic accept;
        @(negedge clk_156m25);
        pkt_rx_avail = 1'b0;
        frm_ready = 1'b1;
        @(posedge clk_156m25);
        #1 frm_ready = 1'b0;
        @(negedge clk_156m25);
        checks++;
        if (frm_valid !== 1'b0) begin
            errors++;
            $display("FAIL accept_drop: frm_valid=%b exp 0", frm_valid);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk_156m25);
        checks++;
        if ({pkt_rx_ren, frm_valid, frm_err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctl: ren/valid/err=%b exp 000",
                     {pkt_rx_ren, frm_valid, frm_err});
        end
        checks++;
        if (frm_len !== 16'd0 || frm_word0 !== 64'd0) begin
            errors++;
            $display("FAIL reset_rec: len=%0d word0=%h exp 0", frm_len, frm_word0);
        end
        checks++;
        if (cnt_good !== 32'd0 || cnt_bad !== 32'd0) begin
            errors++;
            $display("FAIL reset_cnt: good=%0d bad=%0d exp 0", cnt_good, cnt_bad);
        end
        reset_156m25_n = 1'b1;
        @(negedge clk_156m25);
    endtask

    task automatic test_enable;
        enable = 1'b0;
        pkt_rx_avail = 1'b1;
        repeat (5) begin
            @(negedge clk_156m25);
            checks++;
            if (pkt_rx_ren !== 1'b0 || frm_valid !== 1'b0) begin
                errors++;
                $display("FAIL enable_off: ren=%b valid=%b exp 0 0",
                         pkt_rx_ren, frm_valid);
            end
        end
        pkt_rx_avail = 1'b0;
        enable = 1'b1;
    endtask

    task automatic test_64b;
        load_frame(8, 32'hA0A0_0001, 3'd0, 1'b0);
        run_frame(100, 0);
        checks++;
        if (frm_len !== 16'd64 || frm_err !== 1'b0) begin
            errors++;
            $display("FAIL f64_rec: len=%0d err=%b exp 64 0", frm_len, frm_err);
        end
        checks++;
        if (cnt_good !== 32'd1 || cnt_bad !== 32'd0) begin
            errors++;
            $display("FAIL f64_cnt: good=%0d bad=%0d exp 1 0", cnt_good, cnt_bad);
        end
        checks++;
        if (ren_at_eop !== 1'b0) begin
            errors++;
            $display("FAIL f64_ren_eop: ren=%b exp 0", ren_at_eop);
        end
        checks++;
        if (ren_cnt != 8) begin
            errors++;
            $display("FAIL f64_ren_cnt: reads=%0d exp 8", ren_cnt);
        end
        accept();
    endtask

    task automatic test_61b;
        load_frame(8, 32'hB1B1_0002, 3'd5, 1'b0);
        run_frame(100, 0);
        checks++;
        if (frm_len !== 16'd61 || frm_err !== 1'b0) begin
            errors++;
            $display("FAIL f61_rec: len=%0d err=%b exp 61 0", frm_len, frm_err);
        end
        checks++;
        if (frm_word0 !== 64'hB1B1_0002_0000_0000) begin
            errors++;
            $display("FAIL f61_word0: got %h exp b1b1000200000000", frm_word0);
        end
        checks++;
        if (cnt_good !== 32'd2) begin
            errors++;
            $display("FAIL f61_cnt: good=%0d exp 2", cnt_good);
        end
        accept();
    endtask

    task automatic test_mac_err;
        load_frame(16, 32'hC2C2_0003, 3'd0, 1'b1);
        run_frame(100, 0);
        checks++;
        if (frm_len !== 16'd128 || frm_err !== 1'b1) begin
            errors++;
            $display("FAIL macerr_rec: len=%0d err=%b exp 128 1", frm_len, frm_err);
        end
        checks++;
        if (cnt_bad !== 32'd1 || cnt_good !== 32'd2) begin
            errors++;
            $display("FAIL macerr_cnt: good=%0d bad=%0d exp 2 1", cnt_good, cnt_bad);
        end
        accept();
    endtask

    task automatic test_framing;
        load_frame(8, 32'hD3D3_0004, 3'd0, 1'b0);
        fsop[0] = 1'b0;
        run_frame(100, 0);
        checks++;
        if (frm_err !== 1'b1 || frm_len !== 16'd64 || cnt_bad !== 32'd2) begin
            errors++;
            $display("FAIL nosop: err=%b len=%0d bad=%0d exp 1 64 2",
                     frm_err, frm_len, cnt_bad);
        end
        accept();
        load_frame(8, 32'hD3D3_0005, 3'd0, 1'b0);
        fsop[3] = 1'b1;
        run_frame(100, 0);
        checks++;
        if (frm_err !== 1'b1 || frm_len !== 16'd64 || cnt_bad !== 32'd3) begin
            errors++;
            $display("FAIL dupsop: err=%b len=%0d bad=%0d exp 1 64 3",
                     frm_err, frm_len, cnt_bad);
        end
        accept();
    endtask

    task automatic test_timeout;
        nwords = 0;
        run_frame(100, 0);
        checks++;
        if (frm_len !== 16'd0 || frm_err !== 1'b1 || pkt_rx_ren !== 1'b0) begin
            errors++;
            $display("FAIL tmo_rec: len=%0d err=%b ren=%b exp 0 1 0",
                     frm_len, frm_err, pkt_rx_ren);
        end
        checks++;
        if (ren_cnt != 15) begin
            errors++;
            $display("FAIL tmo_ren_cnt: reads=%0d exp 15", ren_cnt);
        end
        checks++;
        if (cnt_bad !== 32'd4) begin
            errors++;
            $display("FAIL tmo_cnt: bad=%0d exp 4", cnt_bad);
        end
        accept();
    endtask

    task automatic test_oversize;
        load_frame(1200, 32'hE4E4_0006, 3'd0, 1'b0);
        run_frame(1400, 0);
        checks++;
        if (frm_len !== 16'd9600 || frm_err !== 1'b0 || cnt_good !== 32'd3) begin
            errors++;
            $display("FAIL max_len: len=%0d err=%b good=%0d exp 9600 0 3",
                     frm_len, frm_err, cnt_good);
        end
        accept();
        load_frame(1201, 32'hE4E4_0007, 3'd0, 1'b0);
        run_frame(1400, 0);
        checks++;
        if (frm_len !== 16'd9608 || frm_err !== 1'b1 || cnt_bad !== 32'd5) begin
            errors++;
            $display("FAIL over_len: len=%0d err=%b bad=%0d exp 9608 1 5",
                     frm_len, frm_err, cnt_bad);
        end
        accept();
    endtask

    task automatic test_back_pressure;
        load_frame(8, 32'hF5F5_0008, 3'd0, 1'b0);
        run_frame(100, 1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_156m25);
            checks++;
            if (pkt_rx_ren !== 1'b0 || frm_valid !== 1'b1 || frm_len !== 16'd64
                || frm_err !== 1'b0 || frm_word0 !== 64'hF5F5_0008_0000_0000) begin
                errors++;
                $display("FAIL bp_hold[%0d]: ren=%b valid=%b len=%0d word0=%h exp 0 1 64 f5f5000800000000",
                         i, pkt_rx_ren, frm_valid, frm_len, frm_word0);
            end
        end
        checks++;
        if (cnt_good !== 32'd4) begin
            errors++;
            $display("FAIL bp_cnt: good=%0d exp 4", cnt_good);
        end
        accept();
    endtask

    task automatic test_clear;
        clr_on_eop = 1'b1;
        load_frame(8, 32'h0606_0009, 3'd0, 1'b0);
        run_frame(100, 0);
        clr_on_eop = 1'b0;
        checks++;
        if (cnt_good !== 32'd0 || cnt_bad !== 32'd0) begin
            errors++;
            $display("FAIL clr_prio: good=%0d bad=%0d exp 0 0", cnt_good, cnt_bad);
        end
        checks++;
        if (frm_len !== 16'd64 || frm_err !== 1'b0) begin
            errors++;
            $display("FAIL clr_rec: len=%0d err=%b exp 64 0", frm_len, frm_err);
        end
        accept();
    endtask

    initial begin
        test_reset();
        test_enable();
        test_64b();
        test_61b();
        test_mac_err();
        test_framing();
        test_timeout();
        test_oversize();
        test_back_pressure();
        test_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
